// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM register, branch resolution, multi-cycle data-memory access, MEM/WB register.
// Latency: non-memory ops 1 edge EX/MEM->MEM/WB; memory ops 1 edge plus the bus wait cycles.
// Backpressure: stall (combinational from mem_ack) holds upstream while an access waits for ack or timeout.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit ALIGN_CHECK    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_ex,
    input  logic [31:0] branch_or_not_address_ex,
    input  logic        zero_ex,
    input  logic [31:0] ALU_result_ex,
    input  logic [31:0] write_data_ex,
    input  logic [4:0]  write_register_ex,
    input  logic        ctrl_memRead_ex,
    input  logic        ctrl_memWrite_ex,
    input  logic        ctrl_branch_ex,
    input  logic        ctrl_regWrite_ex,
    input  logic        ctrl_memToReg_ex,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] read_data_mem_wb,
    output logic [31:0] ALU_result_mem_wb,
    output logic [4:0]  write_register_mem_wb,
    output logic        ctrl_regWrite_mem_wb,
    output logic        ctrl_memToReg_mem_wb,
    output logic        valid_mem_wb,
    output logic        misaligned_fault,
    output logic        bus_error
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Counter value on the last ACCESS cycle before the access is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    // EX/MEM pipeline register
    logic        exm_valid_q;
    logic [31:0] exm_br_addr_q;
    logic        exm_zero_q;
    logic [31:0] exm_alu_q;
    logic [31:0] exm_wdata_q;
    logic [4:0]  exm_wreg_q;
    logic        exm_rd_q;
    logic        exm_wr_q;
    logic        exm_br_q;
    logic        exm_rw_q;
    logic        exm_m2r_q;

    logic        align_en;
    logic        in_is_mem;
    logic        in_access;
    logic        exm_is_mem;
    logic        exm_misaligned;
    logic        in_access_state;
    logic        timeout_hit;

    assign align_en        = ALIGN_CHECK;
    assign in_is_mem       = valid_ex & (ctrl_memRead_ex | ctrl_memWrite_ex);
    // Only aligned memory ops go to the bus; misaligned ones retire straight through as faults.
    assign in_access       = in_is_mem & ~(align_en & (ALU_result_ex[1:0] != 2'b00));
    assign exm_is_mem      = exm_valid_q & (exm_rd_q | exm_wr_q);
    assign exm_misaligned  = align_en & exm_is_mem & (exm_alu_q[1:0] != 2'b00);
    assign in_access_state = (state_q == ACCESS);
    assign timeout_hit     = in_access_state & (cnt_q == TIMEOUT_LAST);

    // Hold everything upstream only while the bus has neither answered nor timed out.
    assign stall = in_access_state & ~mem_ack & ~timeout_hit;

    // Bus drives straight from the held EX/MEM register so they stay stable for the whole access.
    assign mem_req   = in_access_state;
    assign mem_we    = in_access_state & exm_wr_q;
    assign mem_addr  = in_access_state ? exm_alu_q   : 32'd0;
    assign mem_wdata = in_access_state ? exm_wdata_q : 32'd0;

    assign pc_src        = exm_valid_q & exm_br_q & exm_zero_q;
    assign branch_target = exm_br_addr_q;

    // Next state: any unstalled edge captures a new op, which enters ACCESS only if it needs the bus.
    always_comb begin
        state_d = state_q;
        cnt_d   = 8'd0;
        if (stall) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            state_d = in_access ? ACCESS : IDLE;
        end
    end

    // FSM state and wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // EX/MEM capture on every edge where upstream is not held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exm_valid_q   <= 1'b0;
            exm_br_addr_q <= 32'd0;
            exm_zero_q    <= 1'b0;
            exm_alu_q     <= 32'd0;
            exm_wdata_q   <= 32'd0;
            exm_wreg_q    <= 5'd0;
            exm_rd_q      <= 1'b0;
            exm_wr_q      <= 1'b0;
            exm_br_q      <= 1'b0;
            exm_rw_q      <= 1'b0;
            exm_m2r_q     <= 1'b0;
        end else if (!stall) begin
            exm_valid_q   <= valid_ex;
            exm_br_addr_q <= branch_or_not_address_ex;
            exm_zero_q    <= zero_ex;
            exm_alu_q     <= ALU_result_ex;
            exm_wdata_q   <= write_data_ex;
            exm_wreg_q    <= write_register_ex;
            exm_rd_q      <= ctrl_memRead_ex;
            exm_wr_q      <= ctrl_memWrite_ex;
            exm_br_q      <= ctrl_branch_ex;
            exm_rw_q      <= ctrl_regWrite_ex;
            exm_m2r_q     <= ctrl_memToReg_ex;
        end
    end

    // MEM/WB load: pass-through when idle, bubble while waiting, retire on ack or timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data_mem_wb      <= 32'd0;
            ALU_result_mem_wb     <= 32'd0;
            write_register_mem_wb <= 5'd0;
            ctrl_regWrite_mem_wb  <= 1'b0;
            ctrl_memToReg_mem_wb  <= 1'b0;
            valid_mem_wb          <= 1'b0;
            misaligned_fault      <= 1'b0;
            bus_error             <= 1'b0;
        end else if (!in_access_state) begin
            read_data_mem_wb      <= 32'd0;
            ALU_result_mem_wb     <= exm_alu_q;
            write_register_mem_wb <= exm_wreg_q;
            ctrl_regWrite_mem_wb  <= exm_rw_q & ~exm_misaligned;
            ctrl_memToReg_mem_wb  <= exm_m2r_q;
            valid_mem_wb          <= exm_valid_q;
            misaligned_fault      <= exm_misaligned;
            bus_error             <= 1'b0;
        end else if (stall) begin
            // Waiting: emit a bubble so the op is not written back twice.
            ctrl_regWrite_mem_wb  <= 1'b0;
            valid_mem_wb          <= 1'b0;
            misaligned_fault      <= 1'b0;
            bus_error             <= 1'b0;
        end else if (mem_ack) begin
            // Ack takes priority over a timeout landing on the same edge.
            read_data_mem_wb      <= exm_rd_q ? mem_rdata : 32'd0;
            ALU_result_mem_wb     <= exm_alu_q;
            write_register_mem_wb <= exm_wreg_q;
            ctrl_regWrite_mem_wb  <= exm_rw_q;
            ctrl_memToReg_mem_wb  <= exm_m2r_q;
            valid_mem_wb          <= exm_valid_q;
            misaligned_fault      <= 1'b0;
            bus_error             <= 1'b0;
        end else begin
            // Timed out: retire without writing a register.
            read_data_mem_wb      <= 32'd0;
            ALU_result_mem_wb     <= exm_alu_q;
            write_register_mem_wb <= exm_wreg_q;
            ctrl_regWrite_mem_wb  <= 1'b0;
            ctrl_memToReg_mem_wb  <= exm_m2r_q;
            valid_mem_wb          <= exm_valid_q;
            misaligned_fault      <= 1'b0;
            bus_error             <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random op streams against a transaction-level model.
// Expected MEM/WB records, bus accesses and stall totals come from per-op rules, not from the RTL structure.
// The bus responder acks each access after a per-op latency chosen by the stimulus.
module tb_mem_access_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_ex;
    logic [31:0] branch_or_not_address_ex;
    logic        zero_ex;
    logic [31:0] ALU_result_ex;
    logic [31:0] write_data_ex;
    logic [4:0]  write_register_ex;
    logic        ctrl_memRead_ex, ctrl_memWrite_ex, ctrl_branch_ex, ctrl_regWrite_ex, ctrl_memToReg_ex;
    logic        stall, pc_src;
    logic [31:0] branch_target;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [31:0] read_data_mem_wb, ALU_result_mem_wb;
    logic [4:0]  write_register_mem_wb;
    logic        ctrl_regWrite_mem_wb, ctrl_memToReg_mem_wb, valid_mem_wb;
    logic        misaligned_fault, bus_error;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(T), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .reset(reset), .valid_ex(valid_ex),
        .branch_or_not_address_ex(branch_or_not_address_ex), .zero_ex(zero_ex),
        .ALU_result_ex(ALU_result_ex), .write_data_ex(write_data_ex),
        .write_register_ex(write_register_ex),
        .ctrl_memRead_ex(ctrl_memRead_ex), .ctrl_memWrite_ex(ctrl_memWrite_ex),
        .ctrl_branch_ex(ctrl_branch_ex), .ctrl_regWrite_ex(ctrl_regWrite_ex),
        .ctrl_memToReg_ex(ctrl_memToReg_ex),
        .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .read_data_mem_wb(read_data_mem_wb), .ALU_result_mem_wb(ALU_result_mem_wb),
        .write_register_mem_wb(write_register_mem_wb),
        .ctrl_regWrite_mem_wb(ctrl_regWrite_mem_wb), .ctrl_memToReg_mem_wb(ctrl_memToReg_mem_wb),
        .valid_mem_wb(valid_mem_wb), .misaligned_fault(misaligned_fault), .bus_error(bus_error)
    );

    typedef struct {
        logic v; logic [31:0] br_addr; logic zero; logic [31:0] alu; logic [31:0] wdata;
        logic [4:0] wreg; logic rd, wr, br, rw, m2r; int lat; logic [31:0] rdata;
    } op_t;
    typedef struct {
        logic [4:0] wreg; logic [31:0] alu; logic [31:0] rdata; logic rw, m2r, mf, be; int due;
    } wb_t;
    typedef struct {
        logic we; logic [31:0] addr; logic [31:0] wdata; int lat; logic [31:0] rdata;
    } acc_t;

    op_t  stim_q[$];
    wb_t  wb_q[$];
    acc_t acc_q[$];
    op_t  cur, exm_m;
    acc_t acc_cur;
    bit   pending, ack_noise;
    int   cyc, acc_cnt, stall_cnt, pc_cnt, mf_cnt, be_cnt, exp_stall;
    int   n_chk, n_fail;

    function automatic op_t idle_op();
        op_t o;
        o.v = 0; o.br_addr = 0; o.zero = 0; o.alu = 0; o.wdata = 0; o.wreg = 0;
        o.rd = 0; o.wr = 0; o.br = 0; o.rw = 0; o.m2r = 0; o.lat = 1; o.rdata = 0;
        return o;
    endfunction

    function automatic op_t alu_op(input logic [4:0] rd_reg, input logic [31:0] res);
        op_t o = idle_op();
        o.v = 1; o.wreg = rd_reg; o.alu = res; o.rw = 1;
        return o;
    endfunction

    function automatic op_t ld_op(input logic [4:0] rd_reg, input logic [31:0] addr, input int lat,
                                  input logic [31:0] data);
        op_t o = idle_op();
        o.v = 1; o.wreg = rd_reg; o.alu = addr; o.rd = 1; o.rw = 1; o.m2r = 1; o.lat = lat; o.rdata = data;
        return o;
    endfunction

    function automatic op_t st_op(input logic [31:0] addr, input logic [31:0] data, input int lat);
        op_t o = idle_op();
        o.v = 1; o.alu = addr; o.wdata = data; o.wr = 1; o.lat = lat; o.rdata = 32'hBADC0DE5;
        return o;
    endfunction

    function automatic op_t br_op(input logic [31:0] target, input logic z);
        op_t o = idle_op();
        o.v = 1; o.br = 1; o.zero = z; o.br_addr = target; o.alu = $urandom;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int k;
        o = idle_op();
        k = $urandom_range(0, 9);
        o.br_addr = $urandom; o.zero = 1'($urandom_range(0, 1)); o.alu = $urandom; o.wdata = $urandom;
        o.wreg = 5'($urandom); o.rdata = $urandom; o.lat = $urandom_range(1, T + 2);
        o.v = (k != 0);
        if (k == 0) begin
            o.rd = 1'($urandom_range(0, 1)); o.rw = 1'($urandom_range(0, 1));
        end else if (k <= 3) begin
            o.rw = 1;
        end else if (k <= 5) begin
            o.rd = 1; o.rw = 1; o.m2r = 1;
        end else if (k <= 7) begin
            o.wr = 1;
        end else begin
            o.br = 1;
        end
        if ((o.rd || o.wr) && $urandom_range(0, 4) != 0) o.alu[1:0] = 2'b00;
        return o;
    endfunction

    // Reference rules for one valid op captured at edge cap_edge.
    function automatic wb_t model(input op_t o, input int cap_edge, output int waits);
        wb_t w;
        bit  is_mem, mis;
        is_mem = o.rd || o.wr;
        mis    = is_mem && (o.alu % 4 != 0);
        w.wreg = o.wreg; w.alu = o.alu; w.m2r = o.m2r; w.mf = mis; w.be = 0; w.rw = o.rw; w.rdata = 0;
        waits  = 0;
        if (mis) begin
            w.rw = 0;
        end else if (is_mem) begin
            if (o.lat <= T) begin
                waits = o.lat - 1;
                if (o.rd) w.rdata = o.rdata;
            end else begin
                waits = T - 1;
                w.rw = 0;
                w.be = 1;
            end
        end
        w.due = cap_edge + 1 + waits;
        return w;
    endfunction

    task automatic drive(input op_t o);
        valid_ex = o.v; branch_or_not_address_ex = o.br_addr; zero_ex = o.zero;
        ALU_result_ex = o.alu; write_data_ex = o.wdata; write_register_ex = o.wreg;
        ctrl_memRead_ex = o.rd; ctrl_memWrite_ex = o.wr; ctrl_branch_ex = o.br;
        ctrl_regWrite_ex = o.rw; ctrl_memToReg_ex = o.m2r;
    endtask

    // One clock: called at a negedge, checks outputs of the last edge, responds on the bus,
    // presents stimulus, notes capture, and returns at the next negedge.
    task automatic step();
        wb_t e, w;
        int  waits;
        bit  exp_pc;
        n_chk++;
        if (valid_mem_wb) begin
            if (misaligned_fault) mf_cnt++;
            if (bus_error) be_cnt++;
            if (wb_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: valid_mem_wb=1 at edge %0d, required no retire", cyc);
            end else begin
                e = wb_q.pop_front();
                if ({write_register_mem_wb, ALU_result_mem_wb, read_data_mem_wb, ctrl_regWrite_mem_wb,
                     ctrl_memToReg_mem_wb, misaligned_fault, bus_error} !==
                    {e.wreg, e.alu, e.rdata, e.rw, e.m2r, e.mf, e.be} || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL wb_record: got wreg=%0d alu=%h rd=%h rw=%b m2r=%b mf=%b be=%b edge=%0d, required wreg=%0d alu=%h rd=%h rw=%b m2r=%b mf=%b be=%b edge=%0d",
                             write_register_mem_wb, ALU_result_mem_wb, read_data_mem_wb, ctrl_regWrite_mem_wb,
                             ctrl_memToReg_mem_wb, misaligned_fault, bus_error, cyc,
                             e.wreg, e.alu, e.rdata, e.rw, e.m2r, e.mf, e.be, e.due);
                end
            end
        end else if (misaligned_fault || bus_error) begin
            n_fail++;
            $display("FAIL fault_without_valid: mf=%b be=%b, required 0 0", misaligned_fault, bus_error);
        end

        exp_pc = exm_m.v && exm_m.br && exm_m.zero;
        if (pc_src) pc_cnt++;
        n_chk++;
        if ({pc_src, branch_target} !== {exp_pc, exm_m.br_addr}) begin
            n_fail++;
            $display("FAIL branch: got pc_src=%b target=%h, required %b %h", pc_src, branch_target, exp_pc, exm_m.br_addr);
        end

        if (mem_req) begin
            if (acc_cnt == 0) begin
                n_chk++;
                if (acc_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_req: mem_req=1 addr=%h, required 0", mem_addr);
                    acc_cur.we = 0; acc_cur.addr = 0; acc_cur.wdata = 0; acc_cur.lat = T + 1; acc_cur.rdata = 0;
                end else begin
                    acc_cur = acc_q.pop_front();
                end
            end
            acc_cnt++;
            n_chk++;
            if ({mem_we, mem_addr, mem_wdata} !== {acc_cur.we, acc_cur.addr, acc_cur.wdata}) begin
                n_fail++;
                $display("FAIL bus_fields: got we=%b addr=%h wdata=%h, required %b %h %h",
                         mem_we, mem_addr, mem_wdata, acc_cur.we, acc_cur.addr, acc_cur.wdata);
            end
            mem_ack   = (acc_cnt == acc_cur.lat);
            mem_rdata = mem_ack ? acc_cur.rdata : $urandom;
            if (mem_ack || acc_cnt == T) acc_cnt = 0;
        end else begin
            acc_cnt   = 0;
            mem_ack   = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
        end

        if (!pending && stim_q.size() > 0) begin
            cur = stim_q.pop_front();
            pending = 1;
        end else if (!pending) begin
            cur = idle_op();
        end
        drive(cur);
        #1;
        if (stall) begin
            stall_cnt++;
        end else begin
            exm_m = cur;
            if (pending && cur.v) begin
                w = model(cur, cyc + 1, waits);
                wb_q.push_back(w);
                exp_stall += waits;
                if ((cur.rd || cur.wr) && !w.mf)
                    acc_q.push_back('{cur.wr, cur.alu, cur.wdata, cur.lat, cur.rdata});
            end
            pending = 0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 400;
        while ((stim_q.size() > 0 || pending || wb_q.size() > 0 || acc_cnt != 0) && budget > 0) begin
            step();
            budget--;
        end
        n_chk++;
        if (budget == 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d records outstanding after cycle budget, required 0", name, wb_q.size());
        end
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(alu_op(5'd7, 32'hFFFF_FFFF));
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({stall, pc_src, branch_target, mem_req, mem_we, mem_addr, mem_wdata, read_data_mem_wb,
             ALU_result_mem_wb, write_register_mem_wb, ctrl_regWrite_mem_wb, ctrl_memToReg_mem_wb,
             valid_mem_wb, misaligned_fault, bus_error} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall=%b pc=%b req=%b valid=%b alu=%h, required all 0",
                     stall, pc_src, mem_req, valid_mem_wb, ALU_result_mem_wb);
        end
        mem_ack = 1'b0;
        drive(idle_op());
        reset = 1'b1;
    endtask

    task automatic test_alu_op();
        int s0 = stall_cnt;
        stim_q.push_back(alu_op(5'd5, 32'h10));
        drain("alu");
        n_chk++;
        if (stall_cnt - s0 != 0) begin
            n_fail++;
            $display("FAIL alu_stall: got %0d stall cycles, required 0", stall_cnt - s0);
        end
    endtask

    task automatic test_load();
        int s0 = stall_cnt;
        stim_q.push_back(ld_op(5'd9, 32'h100, 4, 32'hDEADBEEF));
        stim_q.push_back(alu_op(5'd3, 32'h77));
        drain("load");
        n_chk++;
        if (stall_cnt - s0 != 3) begin
            n_fail++;
            $display("FAIL load_stall: got %0d stall cycles, required 3", stall_cnt - s0);
        end
    endtask

    task automatic test_store();
        int s0 = stall_cnt;
        stim_q.push_back(st_op(32'h104, 32'h55, 1));
        drain("store");
        n_chk++;
        if (stall_cnt - s0 != 0) begin
            n_fail++;
            $display("FAIL store_stall: got %0d stall cycles, required 0", stall_cnt - s0);
        end
    endtask

    task automatic test_misaligned();
        int s0 = stall_cnt;
        int m0 = mf_cnt;
        stim_q.push_back(ld_op(5'd4, 32'h102, 2, 32'h1111_2222));
        drain("misaligned");
        n_chk++;
        if (stall_cnt - s0 != 0 || mf_cnt - m0 != 1) begin
            n_fail++;
            $display("FAIL misaligned: got stall=%0d faults=%0d, required 0 1", stall_cnt - s0, mf_cnt - m0);
        end
    endtask

    task automatic test_timeout();
        int s0 = stall_cnt;
        int b0 = be_cnt;
        stim_q.push_back(ld_op(5'd6, 32'h200, 99, 32'h0));
        drain("timeout");
        n_chk++;
        if (stall_cnt - s0 != T - 1 || be_cnt - b0 != 1) begin
            n_fail++;
            $display("FAIL timeout: got stall=%0d bus_errors=%0d, required %0d 1", stall_cnt - s0, be_cnt - b0, T - 1);
        end
        s0 = stall_cnt;
        b0 = be_cnt;
        stim_q.push_back(ld_op(5'd6, 32'h204, T, 32'hCAFE_F00D));
        drain("ack_at_limit");
        n_chk++;
        if (stall_cnt - s0 != T - 1 || be_cnt - b0 != 0) begin
            n_fail++;
            $display("FAIL ack_at_limit: got stall=%0d bus_errors=%0d, required %0d 0", stall_cnt - s0, be_cnt - b0, T - 1);
        end
    endtask

    task automatic test_branch();
        int p0 = pc_cnt;
        stim_q.push_back(br_op(32'h40, 1'b1));
        stim_q.push_back(alu_op(5'd1, 32'h5));
        drain("branch_taken");
        n_chk++;
        if (pc_cnt - p0 != 1) begin
            n_fail++;
            $display("FAIL branch_taken: got pc_src high %0d cycles, required 1", pc_cnt - p0);
        end
        p0 = pc_cnt;
        stim_q.push_back(br_op(32'h80, 1'b0));
        drain("branch_not_taken");
        n_chk++;
        if (pc_cnt - p0 != 0) begin
            n_fail++;
            $display("FAIL branch_not_taken: got pc_src high %0d cycles, required 0", pc_cnt - p0);
        end
    endtask

    task automatic test_back_to_back();
        int s0 = stall_cnt;
        stim_q.push_back(ld_op(5'd10, 32'h300, 2, 32'hA5A5_0001));
        stim_q.push_back(st_op(32'h304, 32'h99, 1));
        stim_q.push_back(ld_op(5'd11, 32'h308, 3, 32'hA5A5_0002));
        stim_q.push_back(alu_op(5'd12, 32'h1234));
        stim_q.push_back(br_op(32'h500, 1'b1));
        drain("back_to_back");
        n_chk++;
        if (stall_cnt - s0 != 3) begin
            n_fail++;
            $display("FAIL back_to_back_stall: got %0d stall cycles, required 3", stall_cnt - s0);
        end
    endtask

    task automatic test_random();
        int s0 = stall_cnt;
        int e0 = exp_stall;
        ack_noise = 1;
        for (int i = 0; i < 200; i++) stim_q.push_back(rand_op());
        drain("random");
        ack_noise = 0;
        n_chk++;
        if (stall_cnt - s0 != exp_stall - e0) begin
            n_fail++;
            $display("FAIL random_stall: got %0d stall cycles, required %0d", stall_cnt - s0, exp_stall - e0);
        end
    endtask

    task automatic test_reset_mid_access();
        stim_q.push_back(ld_op(5'd8, 32'h400, 99, 32'h0));
        step();
        n_chk++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_access_setup: got mem_req=%b, required 1", mem_req);
        end
        #2;
        reset = 1'b0;
        #1;
        n_chk++;
        if ({mem_req, stall, valid_mem_wb} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_async: got req=%b stall=%b valid=%b, required 0 0 0", mem_req, stall, valid_mem_wb);
        end
        stim_q.delete(); wb_q.delete(); acc_q.delete();
        acc_cnt = 0; pending = 0; exm_m = idle_op(); mem_ack = 1'b0;
        drive(idle_op());
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        n_chk++;
        if ({mem_req, stall, valid_mem_wb} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release: got req=%b stall=%b valid=%b, required 0 0 0", mem_req, stall, valid_mem_wb);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; acc_cnt = 0; pending = 0; ack_noise = 0;
        stall_cnt = 0; pc_cnt = 0; mf_cnt = 0; be_cnt = 0; exp_stall = 0;
        cur = idle_op(); exm_m = idle_op();
        mem_ack = 1'b0; mem_rdata = 32'd0;
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_branch();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Consumer end of the execute-stage output interface.
- Holds the EX/MEM pipeline register and resolves branches (pc_src, branch_target).
- Performs data-memory loads/stores over a multi-cycle req/ack bus; stalls upstream while a memory access waits.
- Drives the MEM/WB pipeline register that feeds writeback.

Parameters:
TIMEOUT_CYCLES, 255, ACCESS cycles without mem_ack before abort (1..255; 8-bit counter)
ALIGN_CHECK, 1, 1: word accesses with addr[1:0]!=0 fault and skip the bus; 0: no check

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
valid_ex  in  1  EX output holds a real instruction
branch_or_not_address_ex  in  32  branch target from EX
zero_ex  in  1  branch compare result from EX
ALU_result_ex  in  32  ALU result / memory address
write_data_ex  in  32  store data (rt value)
write_register_ex  in  5  destination register
ctrl_memRead_ex, ctrl_memWrite_ex, ctrl_branch_ex, ctrl_regWrite_ex, ctrl_memToReg_ex  in  1 each  control bits
stall  out  1  hold IF/ID, ID/EX and EX outputs this cycle
pc_src  out  1  take branch
branch_target  out  32  target when pc_src=1
mem_req  out  1  bus request
mem_we  out  1  1=store, 0=load
mem_addr  out  32  byte address
mem_wdata  out  32  store data
mem_rdata  in  32  load data, valid with mem_ack
mem_ack  in  1  access complete this cycle
read_data_mem_wb, ALU_result_mem_wb  out  32 each  MEM/WB data
write_register_mem_wb  out  5  MEM/WB destination
ctrl_regWrite_mem_wb, ctrl_memToReg_mem_wb, valid_mem_wb  out  1 each  MEM/WB control
misaligned_fault, bus_error  out  1 each  one-cycle fault pulses, aligned with MEM/WB load

Behaviour:
- Reset (reset=0, async): every output and internal register 0; FSM=IDLE; mem_req drops immediately, including mid-access. The aborted op is discarded; nothing is written back.
- EX/MEM capture: every rising edge with stall=0 loads all *_ex inputs, including valid_ex.
- is_mem = exmem_valid & (memRead|memWrite); misaligned = ALIGN_CHECK & is_mem & addr[1:0]!=0.
- FSM IDLE/ACCESS:
  - IDLE→ACCESS at the edge that captures an aligned memory op. The timeout counter clears on this edge.
  - ACCESS, while waiting: mem_req=1, mem_we=memWrite, mem_addr=ALU_result, mem_wdata=write_data; all stable from EX/MEM. Counter increments each cycle.
  - ACCESS→IDLE on an edge with mem_ack=1 (complete) or counter==TIMEOUT_CYCLES-1 (abort). If both hold on the same edge, ack wins.
  - Back-to-back memory ops go ACCESS→ACCESS: the completion edge also captures the next op.
- stall = (state==ACCESS) & ~mem_ack & ~timeout_hit. This is a combinational path from mem_ack by design.
- MEM/WB load rules:
  - IDLE: each edge loads from EX/MEM.
  - ACCESS, on the completion edge: loads the op with read_data_mem_wb=mem_rdata for loads, 0 for stores.
  - ACCESS, while waiting: each edge loads valid_mem_wb=0 and ctrl_regWrite_mem_wb=0 (a bubble; no double writeback).
  - Non-memory op latency: 1 edge EX/MEM→MEM/WB. Memory op latency: 1 + wait cycles.
- Faults:
  - Misaligned op: never enters ACCESS; passes through in 1 edge with ctrl_regWrite_mem_wb=0, read_data 0, misaligned_fault=1 for that cycle.
  - Timeout: mem_req drops, bus_error=1 for one cycle, op retires with regWrite forced 0 and read_data 0.
- Branch: pc_src = exmem_valid & ctrl_branch & zero; branch_target = EX/MEM branch address. Both are combinational from EX/MEM.
- mem_ack while IDLE is ignored.

Test Plan:
- Reset mid-ACCESS: drive reset=0 while mem_req=1 → mem_req, stall and valid_mem_wb go 0 without waiting for a clock edge; after release, FSM is IDLE.
- ALU op (add, rd=5, ALU_result=0x10, regWrite=1) → after 2 edges valid_mem_wb=1, write_register_mem_wb=5, ALU_result_mem_wb=0x10; stall never asserted.
- Load, addr 0x100, ack after 3 wait cycles with rdata 0xDEADBEEF → stall high 3 cycles; MEM/WB bubbles during the wait; then read_data_mem_wb=0xDEADBEEF and memToReg=1. A following op is captured on the ack edge.
- Store, addr 0x104, data 0x55, ack same cycle as mem_req → mem_we=1, mem_addr=0x104, mem_wdata=0x55, stall=0; MEM/WB valid with regWrite=0.
- Load at addr 0x102 → mem_req never rises, misaligned_fault pulses 1 cycle, ctrl_regWrite_mem_wb=0.
- TIMEOUT_CYCLES=4, no ack → bus_error pulses after 4 ACCESS cycles and mem_req drops. Repeat with ack on cycle 4 → completes normally, bus_error=0.
- Branch (branch=1, zero=1, target 0x40) → pc_src=1 and branch_target=0x40 for exactly 1 cycle. With zero=0 → pc_src stays 0.
